// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one main-memory line port between the I-cache and the D-cache.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise D wins every tie.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 28,
  parameter int unsigned LINE_W = 128
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_I = 2'd1;
  localparam logic [1:0] SERVE_D = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  logic [1:0]        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [LINE_W-1:0] i_rdata_q, d_rdata_q;
  logic              d_req;
  logic              tie_to_d;

  assign d_req = d_read | d_write;

`ifdef MEM_ARB_RR_EN
  assign tie_to_d = (last_grant_q == GRANT_I);
`else
  // last_grant is still tracked so both builds share the same state; D always wins here.
  assign tie_to_d = 1'b1 | last_grant_q;
`endif

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (d_req && (!i_read || tie_to_d)) begin
          state_d      = SERVE_D;
          last_grant_d = GRANT_D;
        end else if (i_read) begin
          state_d      = SERVE_I;
          last_grant_d = GRANT_I;
        end
      end
      SERVE_I: begin
        if (mem_ready) begin
          state_d = DONE;
        end else if (!i_read) begin
          state_d = IDLE;
        end
      end
      SERVE_D: begin
        if (mem_ready) begin
          state_d = DONE;
        end else if (!d_req) begin
          state_d = IDLE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    i_ready   = 1'b0;
    d_ready   = 1'b0;
    case (state_q)
      SERVE_I: begin
        mem_read = i_read;
        mem_addr = i_addr;
        i_ready  = mem_ready;
      end
      SERVE_D: begin
        // A write-back takes precedence over a simultaneous read.
        mem_read  = d_read & ~d_write;
        mem_write = d_write;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        d_ready   = mem_ready;
      end
      default: begin
        mem_read = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_I;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      if (i_ready) begin
        i_rdata_q <= mem_rdata;
      end
      if (d_ready) begin
        d_rdata_q <= mem_rdata;
      end
    end
  end

  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level ownership model checked every cycle plus
// directed scenarios with hand-computed expectations.
module tb_mem_arbiter;

  localparam int unsigned AW = 28;
  localparam int unsigned LW = 128;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          proc_reset = 1'b1;
  logic          i_read = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [LW-1:0] i_rdata;
  logic          i_ready;
  logic          d_read = 1'b0;
  logic          d_write = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [LW-1:0] d_wdata = '0;
  logic [LW-1:0] d_rdata;
  logic          d_ready;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;

  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk       (clk),
    .proc_reset(proc_reset),
    .i_read    (i_read),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_ready   (i_ready),
    .d_read    (d_read),
    .d_write   (d_write),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ready   (d_ready),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  initial forever #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the memory port (0 none, 1 I, 2 D) and whether a release cycle is pending.
  int            m_owner = 0;
  bit            m_cool  = 1'b0;
  int            m_last  = 1;
  logic [LW-1:0] m_irdata = '0;
  logic [LW-1:0] m_drdata = '0;
  int            i_pulses = 0;
  int            d_pulses = 0;

  task automatic model_step();
    int win;
    bit dreq;
    dreq = d_read | d_write;
    if (proc_reset) begin
      m_owner = 0; m_cool = 1'b0; m_last = 1; m_irdata = '0; m_drdata = '0;
    end else if (m_cool) begin
      m_cool = 1'b0;
    end else if (m_owner == 0) begin
      win = 0;
      if (i_read && dreq) win = RR ? ((m_last == 1) ? 2 : 1) : 2;
      else if (dreq) win = 2;
      else if (i_read) win = 1;
      if (win != 0) begin
        m_owner = win;
        m_last  = win;
      end
    end else if (mem_ready) begin
      if (m_owner == 1) m_irdata = mem_rdata;
      else m_drdata = mem_rdata;
      m_owner = 0;
      m_cool  = 1'b1;
    end else if ((m_owner == 1 && !i_read) || (m_owner == 2 && !dreq)) begin
      m_owner = 0;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    logic          e_rd, e_wr, e_ir, e_dr;
    logic [AW-1:0] e_addr;
    logic [LW-1:0] e_wdata;
    @(negedge clk);
    e_rd = 1'b0; e_wr = 1'b0; e_ir = 1'b0; e_dr = 1'b0; e_addr = '0; e_wdata = '0;
    if (m_owner == 1) begin
      e_rd = i_read; e_addr = i_addr; e_ir = mem_ready;
    end else if (m_owner == 2) begin
      e_rd = d_read & ~d_write; e_wr = d_write; e_addr = d_addr; e_wdata = d_wdata;
      e_dr = mem_ready;
    end
    check("cyc_mem_read", mem_read, e_rd);
    check("cyc_mem_write", mem_write, e_wr);
    check("cyc_mem_addr", mem_addr, e_addr);
    check("cyc_mem_wdata", mem_wdata, e_wdata);
    check("cyc_i_ready", i_ready, e_ir);
    check("cyc_d_ready", d_ready, e_dr);
    check("cyc_i_rdata", i_rdata, m_irdata);
    check("cyc_d_rdata", d_rdata, m_drdata);
    if (i_ready === 1'b1) i_pulses++;
    if (d_ready === 1'b1) d_pulses++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [LW-1:0] LINE_A5 = {16{8'hA5}};
  localparam logic [LW-1:0] LINE_W1 = 128'h123456789ABCDEF0_0FEDCBA987654321;
  localparam logic [LW-1:0] LINE_R1 = {4{32'hDEADBEEF}};
  localparam logic [LW-1:0] LINE_R2 = {4{32'h0BAD_F00D}};
  localparam logic [LW-1:0] LINE_R3 = {4{32'hCAFE_0042}};
  localparam logic [LW-1:0] LINE_FF = {LW{1'b1}};

  initial begin
    int order[4];
    int exp_order[4];
    int w;
    int pre;

    tick(); tick();
    proc_reset = 1'b0;
    check("reset_strobes", {mem_read, mem_write, i_ready, d_ready}, 4'b0000);
    check("reset_mem_addr", mem_addr, 0);
    check("reset_i_rdata", i_rdata, 0);
    check("reset_d_rdata", d_rdata, 0);

    // Lone I-read, memory answers three cycles after mem_read first rises.
    i_read = 1'b1; i_addr = 28'h0000010;
    tick();
    check("i_mem_addr", mem_addr, 28'h0000010);
    check("i_mem_read", mem_read, 1'b1);
    tick(); tick(); tick();
    mem_ready = 1'b1; mem_rdata = LINE_A5;
    #1;
    check("i_ready_pulse", i_ready, 1'b1);
    check("i_no_d_ready", d_ready, 1'b0);
    tick();
    mem_ready = 1'b0; mem_rdata = '0; i_read = 1'b0;
    check("i_rdata_line", i_rdata, LINE_A5);
    check("model_i_rdata", m_irdata, LINE_A5);
    check("i_pulse_count", i_pulses, 1);
    check("i_d_pulse_count", d_pulses, 0);
    tick();

    // D write-back; request held into the release cycle must be ignored there.
    d_write = 1'b1; d_addr = 28'h0000123; d_wdata = LINE_W1;
    tick();
    check("dw_mem_write", mem_write, 1'b1);
    check("dw_mem_read", mem_read, 1'b0);
    check("dw_mem_wdata", mem_wdata, LINE_W1);
    check("dw_mem_addr", mem_addr, 28'h0000123);
    tick();
    mem_ready = 1'b1; mem_rdata = LINE_R1;
    #1;
    check("dw_d_ready", d_ready, 1'b1);
    check("dw_no_i_ready", i_ready, 1'b0);
    tick();
    mem_ready = 1'b0;
    #1;
    check("dw_done_quiet", mem_write, 1'b0);
    check("dw_d_rdata", d_rdata, LINE_R1);
    tick();
    check("dw_idle_quiet", mem_write, 1'b0);
    d_write = 1'b0;
    tick();

    // Tie straight after reset: D first under either priority mode.
    proc_reset = 1'b1;
    tick();
    proc_reset = 1'b0;
    i_read = 1'b1; i_addr = 28'h0000200; d_read = 1'b1; d_addr = 28'h0000300;
    tick();
    check("tie_first_addr", mem_addr, 28'h0000300);
    check("tie_first_read", mem_read, 1'b1);
    tick();
    mem_ready = 1'b1; mem_rdata = LINE_R2;
    tick();
    mem_ready = 1'b0; d_read = 1'b0;
    check("tie_gap1", mem_read, 1'b0);
    tick();
    check("tie_gap2", mem_read, 1'b0);
    tick();
    check("tie_second_read", mem_read, 1'b1);
    check("tie_second_addr", mem_addr, 28'h0000200);
    mem_ready = 1'b1; mem_rdata = LINE_R3;
    tick();
    mem_ready = 1'b0; i_read = 1'b0;
    check("tie_i_rdata", i_rdata, LINE_R3);
    check("tie_d_rdata", d_rdata, LINE_R2);
    tick();

    // Both sides requesting continuously for four transactions.
    proc_reset = 1'b1;
    tick();
    proc_reset = 1'b0;
    i_read = 1'b1; d_read = 1'b1;
    exp_order = RR ? '{2, 1, 2, 1} : '{2, 2, 2, 2};
    for (int k = 0; k < 4; k++) begin
      w = 0;
      while (mem_read !== 1'b1 && w < 10) begin
        tick();
        w++;
      end
      check("cont_grant_timeout", mem_read, 1'b1);
      order[k] = (mem_addr == d_addr) ? 2 : 1;
      tick();
      mem_ready = 1'b1; mem_rdata = LINE_R1 ^ LW'(k);
      tick();
      mem_ready = 1'b0;
    end
    i_read = 1'b0; d_read = 1'b0;
    for (int k = 0; k < 4; k++) check("cont_grant_order", order[k], exp_order[k]);
    tick(); tick();

    // Reset while D is waiting on memory.
    pre = d_pulses;
    d_read = 1'b1; d_addr = 28'h0000444;
    tick();
    tick();
    proc_reset = 1'b1;
    tick();
    check("rst_mem_read", mem_read, 1'b0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_d_ready", d_ready, 1'b0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_i_rdata", i_rdata, 0);
    proc_reset = 1'b0; d_read = 1'b0;
    tick();
    check("rst_no_d_pulse", d_pulses, pre);

    // Abort: I drops its request mid-grant; a late mem_ready must be ignored.
    pre = i_pulses;
    i_read = 1'b1; i_addr = 28'h0000555;
    tick();
    check("abort_granted", mem_read, 1'b1);
    i_read = 1'b0;
    tick();
    mem_ready = 1'b1; mem_rdata = LINE_FF;
    #1;
    check("abort_late_ready", i_ready, 1'b0);
    check("abort_idle_quiet", mem_read, 1'b0);
    tick();
    mem_ready = 1'b0;
    check("abort_i_rdata", i_rdata, 0);
    check("abort_no_pulse", i_pulses, pre);
    check("model_abort_owner", m_owner, 0);
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single 128-bit main-memory port between the instruction cache (read-only) and the data cache (read/write-back) in the pipelined RISC-V core. It grants one cache at a time, forwards that cache's block request to memory, and captures the returned line. It then hands `ready` and the line back to the granted cache. It sits between the two L1 caches' `mem_*` interfaces and the memory / L2 port.

## Interface
- `ADDR_W`, 28: block address width, in 16-byte lines.
- `LINE_W`, 128: line width.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `proc_reset`  in  1  synchronous, active-high reset.
- `i_read`  in  1  I-cache line read request; held high until serviced.
- `i_addr`  in  ADDR_W  I-cache line address.
- `i_rdata`  out  LINE_W  returned line for the I-cache (registered).
- `i_ready`  out  1  one-cycle completion pulse to the I-cache.
- `d_read`, `d_write`  in  1 each  D-cache read / write-back request; held until serviced.
- `d_addr`  in  ADDR_W  D-cache line address.
- `d_wdata`  in  LINE_W  D-cache write-back line.
- `d_rdata`  out  LINE_W  returned line for the D-cache (registered).
- `d_ready`  out  1  one-cycle completion pulse to the D-cache.
- `mem_read`, `mem_write`  out  1 each  memory request strobes.
- `mem_addr`  out  ADDR_W  memory line address.
- `mem_wdata`  out  LINE_W  memory write line.
- `mem_rdata`  in  LINE_W  memory read line; valid only in the `mem_ready` cycle.
- `mem_ready`  in  1  memory completion pulse.

## Operation
- **FSM states:** `IDLE`, `SERVE_I`, `SERVE_D`, `DONE`.
- **`IDLE`:**
  - All `mem_*` outputs are 0.
  - Samples `i_read` and `d_req` (`d_read | d_write`) and picks the winner per the priority rule (see Configuration).
  - Winner goes to `SERVE_I` or `SERVE_D`; with no request, stays in `IDLE`.
- **`SERVE_x`, forwarding:**
  - `mem_addr` = granted address.
  - `mem_read` = granted read.
  - `mem_write` / `mem_wdata` = `d_write` / `d_wdata`; I side always `mem_write = 0` and `mem_wdata = 0`.
  - If `d_read` and `d_write` are both high, only `mem_write` is forwarded.
- **`SERVE_x`, completion:** on `mem_ready`:
  - `mem_rdata` is latched into the granted side's `x_rdata` register.
  - `x_ready` pulses high for that same cycle (combinational: `mem_ready` AND state).
  - Next state is `DONE`.
- **`SERVE_x`, abort:** if the granted requester drops its request before `mem_ready`, go to `IDLE` with no ready pulse and no data capture.
- **Non-granted side:** `x_ready` = 0 and `x_rdata` holds its old value.
- **`DONE`:**
  - One-cycle release: `mem_*` = 0 and requests are ignored.
  - Covers the cycle in which the cache consumes its registered ready and drops its request.
  - Next state is `IDLE`.
- **`last_grant` register:** updated on each transition into `SERVE_x`.
- **`mem_ready` outside `SERVE_x`:** ignored.

## Timing
- **Reset values:**
  - state = `IDLE`, `last_grant` = I.
  - `i_rdata`, `d_rdata` = 0.
  - `i_ready`, `d_ready`, `mem_read`, `mem_write` = 0.
  - `mem_addr`, `mem_wdata` = 0.
- **Arbitration latency:** 1 cycle. A request seen in `IDLE` at cycle t drives `mem_*` from t+1.
- **Memory ready at cycle m:** `x_ready` is high at m and `x_rdata` is valid from m+1.
- **Turnaround:** state is `DONE` at m+1 and `IDLE` at m+2, so a minimum of 2 idle cycles separate back-to-back grants.
- **Reset mid-transaction:** reset in any state returns to `IDLE` next edge, drops `mem_*` immediately after that edge, and emits no ready pulse.
- **No pre-emption:** a grant is held until `mem_ready` or abort.
- **Simultaneous requests in `IDLE`:** resolved per the priority rule; the loser stays pending and is served next round.

## Configuration
- **`MEM_ARB_RR_EN` defined:** round-robin priority.
  - On a tie, the side not equal to `last_grant` wins.
  - The first tie after reset goes to D.
- **`MEM_ARB_RR_EN` undefined:** fixed priority, D over I, on every tie; `last_grant` is still maintained but unused.

## Test plan
- **Lone I-read:** reset, `i_read` = 1, `i_addr` = 28'h0000010; memory returns `mem_ready` 3 cycles after `mem_read`, with `mem_rdata` = 128'hA5...A5.
  - `mem_addr` = 28'h0000010 from the cycle after request.
  - `i_ready` pulses once.
  - `i_rdata` = A5... next cycle.
  - `d_ready` stays 0.
- **D write-back:** `d_write` = 1, `d_addr` = 28'h0000123, `d_wdata` = 128'h1234...
  - `mem_write` = 1 and `mem_read` = 0, with `mem_wdata` matching.
  - `d_ready` pulse, then `DONE`, then `IDLE`.
- **Tie, fixed priority (macro off):** `i_read` and `d_read` rise together.
  - D is served first, then I.
  - `mem_read` is low for exactly 2 cycles between the two transactions.
- **Tie, round-robin (`MEM_ARB_RR_EN` on):** both sides requesting continuously for 4 transactions.
  - Grant order is D, I, D, I.
- **Reset mid-`SERVE_D`:** assert `proc_reset` with `mem_ready` still pending.
  - Next cycle all outputs are 0, no `d_ready` pulse, and `d_rdata` = 0.
- **Abort:** drop `i_read` while in `SERVE_I`.
  - `IDLE` next cycle, no `i_ready`, and `i_rdata` unchanged.
  - A late `mem_ready` is ignored.
